core_mem_port: RTL and testbench

Per-core initiator side of the shared-RAM arbitration protocol. Each processor core instantiates one to turn a single load or store from its control unit into the controller's request/acknowledge handshake: it drives rden/wren/address/data, waits for acq, holds for the RAM latency, captures read data and releases the bus. It sits between the core's execute stage and one ncores-wide slice of the memory controller's request ports.

---
 rtl/mem_port_pkg.sv | 6 +
 rtl/mem_port_cnt.sv | 19 +
 rtl/core_mem_port.sv | 124 ++++++++++++
 tb/tb_core_mem_port.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_pkg.sv
// mem_port_pkg: initiator state encoding and data/address widths shared with the memory controller
package mem_port_pkg;
   localparam int MEM_DATA_W = 8;
   localparam int MEM_ADDR_W = 8;
   typedef enum logic [1:0] {IDLE, REQ, XFER, REL} state_e;
endpackage

// File: rtl/mem_port_cnt.sv
// mem_port_cnt: clearable, enabled, saturating up-counter with terminal compare
module mem_port_cnt #(
   parameter int W = 7
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr_i,
   input  logic         en_i,
   input  logic [W-1:0] limit_i,
   output logic         term_o
);
   logic [W-1:0] cnt_q, cnt_d;
   always_comb cnt_d = clr_i ? '0 : (en_i && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else cnt_q <= cnt_d;
   end
   assign term_o = (cnt_q == limit_i);
endmodule

// File: rtl/core_mem_port.sv
// core_mem_port: per-core load/store initiator for the shared-RAM request/acknowledge handshake
module core_mem_port
   import mem_port_pkg::*;
#(
   parameter int DATA_W  = MEM_DATA_W,
   parameter int ADDR_W  = MEM_ADDR_W,
   parameter int RD_LAT  = 2,
   parameter int WR_LAT  = 1,
   parameter int TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] rdata,
   output logic              err,
   output logic              mem_rden,
   output logic              mem_wren,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   input  logic [DATA_W-1:0] mem_dq,
   input  logic              mem_acq
);
   localparam int CW = $clog2(TIMEOUT) + 1;
   state_e state_q, state_d;
   logic ok_q, ok_d, busy_q, done_q, done_d, err_q, err_d;
   logic rden_q, rden_d, wren_q, wren_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] din_q, din_d, rdata_q, rdata_d;
   logic cnt_clr, cnt_en, cnt_term;
   logic [CW-1:0] cnt_lim;
   // one counter serves both the grant timeout and the transfer latency
   assign cnt_lim = (state_q == REQ) ? CW'(TIMEOUT - 1) : wren_q ? CW'(WR_LAT - 1) : CW'(RD_LAT - 1);
   mem_port_cnt #(.W(CW)) u_cnt (
      .clk(clk), .rst(rst), .clr_i(cnt_clr), .en_i(cnt_en), .limit_i(cnt_lim), .term_o(cnt_term)
   );
   always_comb begin
      state_d = state_q;
      ok_d    = ok_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      rden_d  = rden_q;
      wren_d  = wren_q;
      addr_d  = addr_q;
      din_d   = din_q;
      rdata_d = rdata_q;
      cnt_clr = 1'b0;
      cnt_en  = 1'b0;
      case (state_q)
         IDLE: if (start) begin
            addr_d  = addr;
            din_d   = wdata;
            rden_d  = !we;
            wren_d  = we;
            ok_d    = 1'b0;
            cnt_clr = 1'b1;
            state_d = REQ;
         end
         REQ: if (mem_acq) begin
            cnt_clr = 1'b1;
            state_d = XFER;
         end else if (cnt_term) begin
            rden_d  = 1'b0;
            wren_d  = 1'b0;
            err_d   = 1'b1;
            state_d = REL;
         end else cnt_en = 1'b1;
         XFER: if (!mem_acq) begin
            rden_d  = 1'b0;
            wren_d  = 1'b0;
            err_d   = 1'b1;
            state_d = REL;
         end else if (cnt_term) begin
            rdata_d = wren_q ? rdata_q : mem_dq;
            rden_d  = 1'b0;
            wren_d  = 1'b0;
            ok_d    = 1'b1;
            state_d = REL;
         end else cnt_en = 1'b1;
         REL: if (!mem_acq) begin
            done_d  = ok_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ok_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         rden_q  <= 1'b0;
         wren_q  <= 1'b0;
         addr_q  <= '0;
         din_q   <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         ok_q    <= ok_d;
         busy_q  <= (state_d != IDLE);
         done_q  <= done_d;
         err_q   <= err_d;
         rden_q  <= rden_d;
         wren_q  <= wren_d;
         addr_q  <= addr_d;
         din_q   <= din_d;
         rdata_q <= rdata_d;
      end
   end
   assign busy     = busy_q;
   assign done     = done_q;
   assign err      = err_q;
   assign rdata    = rdata_q;
   assign mem_rden = rden_q;
   assign mem_wren = wren_q;
   assign mem_addr = addr_q;
   assign mem_din  = din_q;
endmodule

// File: tb/tb_core_mem_port.sv
// tb_core_mem_port: random and directed traffic against a deadline-based protocol model of core_mem_port
module tb_core_mem_port;
   localparam int DW = 8, AW = 8, RD_LAT = 2, WR_LAT = 1, TIMEOUT = 64;
   logic clk = 1'b0;
   logic rst, start, we, busy, done, err, mem_rden, mem_wren, mem_acq;
   logic [AW-1:0] addr, mem_addr;
   logic [DW-1:0] wdata, rdata, mem_din, mem_dq;
   int n_cmp = 0, n_bad = 0, cyc = 0;
   int ph = 0, t_dead = 0, t_end = 0;
   logic m_busy, m_done, m_err, m_rden, m_wren, m_ok;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_din, m_rdata;
   int ctl_delay = 0, ctl_linger = 0, ctl_drop = -1;
   logic ctl_never = 1'b0, dq_rand = 1'b0;
   logic [DW-1:0] dq_val = '0;
   int c_wait = 0, c_held = 0, c_lin = 0;
   logic c_lost = 1'b0;
   int n_done = 0, n_err = 0, n_rden = 0, n_wren = 0, n_rise = 0, n_stale = 0;
   int rise_cyc = 0, done_cyc = 0, err_cyc = 0;
   logic prev_busy = 1'b0, prev_req = 1'b0, prev_acq = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [DW-1:0] wr_din = '0;
   int s_done, s_err, s_rden, s_wren, s_rise, s_stale;
   localparam int P_IDLE = 0, P_WAIT = 1, P_XFER = 2, P_REL = 3;

   core_mem_port #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .start(start), .we(we), .addr(addr), .wdata(wdata),
      .busy(busy), .done(done), .rdata(rdata), .err(err),
      .mem_rden(mem_rden), .mem_wren(mem_wren), .mem_addr(mem_addr), .mem_din(mem_din),
      .mem_dq(mem_dq), .mem_acq(mem_acq)
   );

   initial forever #5 clk = ~clk;

   // protocol model: absolute edge deadlines for grant timeout and transfer completion
   always @(posedge clk) begin
      cyc <= cyc + 1;
      m_done <= 1'b0;
      m_err <= 1'b0;
      if (rst) begin
         ph <= P_IDLE; m_busy <= 1'b0; m_rden <= 1'b0; m_wren <= 1'b0;
         m_addr <= '0; m_din <= '0; m_rdata <= '0; m_ok <= 1'b0;
      end else if (ph == P_IDLE) begin
         if (start) begin
            m_addr <= addr; m_din <= wdata; m_rden <= !we; m_wren <= we;
            m_busy <= 1'b1; m_ok <= 1'b0; t_dead <= cyc + TIMEOUT; ph <= P_WAIT;
         end
      end else if (ph == P_WAIT) begin
         if (mem_acq) begin
            t_end <= cyc + (m_wren ? WR_LAT : RD_LAT); ph <= P_XFER;
         end else if (cyc == t_dead) begin
            m_rden <= 1'b0; m_wren <= 1'b0; m_err <= 1'b1; ph <= P_REL;
         end
      end else if (ph == P_XFER) begin
         if (!mem_acq) begin
            m_rden <= 1'b0; m_wren <= 1'b0; m_err <= 1'b1; ph <= P_REL;
         end else if (cyc == t_end) begin
            if (m_rden) m_rdata <= mem_dq;
            m_rden <= 1'b0; m_wren <= 1'b0; m_ok <= 1'b1; ph <= P_REL;
         end
      end else if (!mem_acq) begin
         m_busy <= 1'b0; m_done <= m_ok; ph <= P_IDLE;
      end
   end

   // memory controller stand-in: grant delay, optional grant loss, grant linger after release
   initial begin
      mem_acq = 1'b0;
      mem_dq = '0;
      forever begin
         @(posedge clk);
         #1;
         mem_dq = dq_rand ? DW'($urandom) : dq_val;
         if (mem_rden | mem_wren) begin
            c_lin = 0;
            if (mem_acq) begin
               c_held++;
               if (ctl_drop >= 0 && c_held > ctl_drop) begin mem_acq = 1'b0; c_lost = 1'b1; end
            end else if (!ctl_never && !c_lost) begin
               if (c_wait >= ctl_delay) mem_acq = 1'b1; else c_wait++;
            end
         end else begin
            c_wait = 0; c_held = 0; c_lost = 1'b0;
            if (mem_acq) begin
               if (c_lin >= ctl_linger) mem_acq = 1'b0; else c_lin++;
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
      end
   endtask

   initial forever begin
      @(negedge clk);
      if (cyc > 0) begin
         chk("busy", 32'(busy), 32'(m_busy));
         chk("done", 32'(done), 32'(m_done));
         chk("err", 32'(err), 32'(m_err));
         chk("mem_rden", 32'(mem_rden), 32'(m_rden));
         chk("mem_wren", 32'(mem_wren), 32'(m_wren));
         chk("mem_addr", 32'(mem_addr), 32'(m_addr));
         chk("mem_din", 32'(mem_din), 32'(m_din));
         chk("rdata", 32'(rdata), 32'(m_rdata));
         chk("done_and_err", 32'(done & err), 32'd0);
         n_done += int'(done); n_err += int'(err);
         n_rden += int'(mem_rden); n_wren += int'(mem_wren);
         if (busy && !prev_busy) begin n_rise++; rise_cyc = cyc; end
         if (done) done_cyc = cyc;
         if (err) err_cyc = cyc;
         if (mem_wren) begin wr_addr = mem_addr; wr_din = mem_din; end
         if ((mem_rden | mem_wren) && !prev_req && prev_acq) n_stale++;
      end
      prev_busy = busy; prev_req = mem_rden | mem_wren; prev_acq = mem_acq;
   end

   task automatic go(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      @(negedge clk);
      start = 1'b1; we = w; addr = a; wdata = d;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (busy && n < budget) begin @(negedge clk); n++; end
      chk("idle_wait_busy", 32'(busy), 32'd0);
      @(negedge clk);
   endtask

   task automatic snap();
      s_done = n_done; s_err = n_err; s_rden = n_rden; s_wren = n_wren; s_rise = n_rise; s_stale = n_stale;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; we = 1'b0; addr = '0; wdata = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rdata", 32'(rdata), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_req", 32'({mem_rden, mem_wren}), 32'd0);
      rst = 1'b0;
      dq_val = 8'hA5; snap();
      go(1'b0, 8'h10, 8'h00); wait_idle(50);
      chk("t1_rdata", 32'(rdata), 32'hA5);
      chk("t1_rden_cycles", 32'(n_rden - s_rden), 32'd3);
      chk("t1_done", 32'(n_done - s_done), 32'd1);
      chk("t1_err", 32'(n_err - s_err), 32'd0);
      chk("t1_latency", 32'(done_cyc - rise_cyc), 32'd4);
      snap();
      go(1'b1, 8'h3C, 8'h5A); wait_idle(50);
      chk("t2_wr_addr", 32'(wr_addr), 32'h3C);
      chk("t2_wr_din", 32'(wr_din), 32'h5A);
      chk("t2_wren_cycles", 32'(n_wren - s_wren), 32'd2);
      chk("t2_done", 32'(n_done - s_done), 32'd1);
      chk("t2_rdata_kept", 32'(rdata), 32'hA5);
      ctl_never = 1'b1; snap();
      go(1'b0, 8'h77, 8'h00); wait_idle(100);
      chk("t3_err", 32'(n_err - s_err), 32'd1);
      chk("t3_done", 32'(n_done - s_done), 32'd0);
      chk("t3_err_time", 32'(err_cyc - rise_cyc), 32'd64);
      chk("t3_rdata_kept", 32'(rdata), 32'hA5);
      ctl_never = 1'b0; ctl_delay = 3; dq_val = 8'h4C; snap();
      go(1'b0, 8'h21, 8'h00);
      repeat (5) begin
         start = 1'b1; we = 1'($urandom); addr = AW'($urandom); wdata = DW'($urandom);
         @(negedge clk);
      end
      start = 1'b0;
      wait_idle(50);
      chk("t4_accepts", 32'(n_rise - s_rise), 32'd1);
      chk("t4_done", 32'(n_done - s_done), 32'd1);
      chk("t4_mem_addr", 32'(mem_addr), 32'h21);
      chk("t4_rdata", 32'(rdata), 32'h4C);
      ctl_delay = 0; snap();
      go(1'b0, 8'h33, 8'h00);
      @(negedge clk);
      chk("t5_in_xfer", 32'(mem_acq & mem_rden & busy), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("t5_rst_busy", 32'(busy), 32'd0);
      chk("t5_rst_rden", 32'(mem_rden), 32'd0);
      chk("t5_rst_addr", 32'(mem_addr), 32'd0);
      chk("t5_rst_rdata", 32'(rdata), 32'd0);
      dq_val = 8'h11;
      go(1'b0, 8'h34, 8'h00); wait_idle(50);
      chk("t5_rdata", 32'(rdata), 32'h11);
      chk("t5_done", 32'(n_done - s_done), 32'd1);
      chk("t5_err", 32'(n_err - s_err), 32'd0);
      ctl_linger = 2; dq_val = 8'h6E; snap();
      go(1'b0, 8'h40, 8'h00); wait_idle(50);
      chk("t6_load_latency", 32'(done_cyc - rise_cyc), 32'd6);
      go(1'b1, 8'h41, 8'h77); wait_idle(50);
      chk("t6_store_latency", 32'(done_cyc - rise_cyc), 32'd5);
      chk("t6_done", 32'(n_done - s_done), 32'd2);
      chk("t6_stale_req", 32'(n_stale - s_stale), 32'd0);
      chk("t6_rdata", 32'(rdata), 32'h6E);
      dq_rand = 1'b1;
      for (int i = 0; i < 300; i++) begin
         ctl_delay = $urandom_range(0, 4);
         ctl_linger = $urandom_range(0, 3);
         ctl_never = ($urandom_range(0, 19) == 0);
         ctl_drop = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 2)) : -1;
         go(1'($urandom), AW'($urandom), DW'($urandom));
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 4)) begin
               start = 1'b1; we = 1'($urandom); addr = AW'($urandom); wdata = DW'($urandom);
               @(negedge clk);
            end
            start = 1'b0;
         end
         if ($urandom_range(0, 24) == 0) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
         end
         wait_idle(200);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end
endmodule
